// File: rtl/fx2fp_pkg.sv
// fx2fp_pkg: shared FSM state, float constants and default slot period
package fx2fp_pkg;
    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
    localparam int FP32_BIAS = 127;
    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam int DEFAULT_PERIOD = 11;
endpackage

// File: rtl/int_to_fp32.sv
// int_to_fp32: two-stage exact two's-complement integer to IEEE-754 single conversion
// Ports: clk, reset (sync, active-high); in_valid/in_data sample in; busy = a stage is occupied;
// out_valid/out_data result two cycles after in_valid.
module int_to_fp32
    import fx2fp_pkg::*;
#(
    parameter int IN_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [IN_W-1:0] in_data,
    output logic            busy,
    output logic            out_valid,
    output logic [31:0]     out_data
);
    logic            s1_v;
    logic            s1_sign;
    logic [IN_W-1:0] s1_mag;
    logic [4:0]      lead;
    logic [22:0]     mant;
    always_comb begin
        lead = '0;
        for (int i = 0; i < IN_W; i++)
            if (s1_mag[i]) lead = 5'(i);
    end
    // Shift the leading one up to bit 23; the 23 bits below it are the mantissa.
    assign mant = 23'(24'(s1_mag) << (5'd23 - lead));
    assign busy = s1_v | out_valid;
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v <= 1'b0;
            s1_sign <= 1'b0;
            s1_mag <= '0;
            out_valid <= 1'b0;
            out_data <= FP32_ZERO;
        end else begin
            s1_v <= in_valid;
            out_valid <= s1_v;
            if (in_valid) begin
                s1_sign <= in_data[IN_W-1];
                // As an unsigned value, -(-2^(IN_W-1)) is 2^(IN_W-1), which still fits.
                s1_mag <= in_data[IN_W-1] ? -in_data : in_data;
            end
            if (s1_v)
                out_data <= (s1_mag == '0) ? FP32_ZERO : {s1_sign, 8'(FP32_BIAS) + {3'b000, lead}, mant};
        end
    end
endmodule

// File: rtl/fx2fp_feeder.sv
// fx2fp_feeder: converts fixed-point samples to float and paces them into a filter, one per PERIOD-cycle slot
// Ports: clk, reset (sync, active-high); s_valid/s_data/s_ready upstream handshake;
// start, o_sample, o_strobe, underrun toward the filter.
// Macro FX2FP_FEEDER_STATS_EN adds underrun_cnt, a saturating count of underrun pulses.
module fx2fp_feeder
    import fx2fp_pkg::*;
#(
    parameter int PERIOD = DEFAULT_PERIOD,
    parameter int IN_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_valid,
    input  logic [IN_W-1:0] s_data,
    output logic            s_ready,
    output logic            start,
    output logic [31:0]     o_sample,
    output logic            o_strobe,
    output logic            underrun
`ifdef FX2FP_FEEDER_STATS_EN
    ,
    output logic [15:0]     underrun_cnt
`endif
);
    state_t      state;
    logic [7:0]  cnt;
    logic        c_busy, c_valid, hold_v, h_v, bnd, take, xfer;
    logic [31:0] c_data, hold_d, h_d;
    int_to_fp32 #(.IN_W(IN_W)) u_conv (
        .clk(clk),
        .reset(reset),
        .in_valid(xfer),
        .in_data(s_data),
        .busy(c_busy),
        .out_valid(c_valid),
        .out_data(c_data)
    );
    // The converter result counts as held on the cycle it appears, so it can be consumed without an extra cycle.
    assign h_v = hold_v | c_valid;
    assign h_d = c_valid ? c_data : hold_d;
    assign s_ready = !reset && !c_busy && !hold_v;
    assign xfer = s_valid && s_ready;
    assign bnd = (state == RUN) && (cnt == 8'(PERIOD - 1));
    assign take = h_v && ((state == FILL) || bnd);
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            hold_v <= 1'b0;
            hold_d <= FP32_ZERO;
            o_sample <= FP32_ZERO;
            start <= 1'b0;
            o_strobe <= 1'b0;
            underrun <= 1'b0;
        end else begin
            hold_v <= h_v && !take;
            hold_d <= h_d;
            o_strobe <= take;
            underrun <= bnd && !h_v;
            if (take) o_sample <= h_d;
            cnt <= (state == RUN && !bnd) ? cnt + 8'd1 : '0;
            start <= (state == RUN) || (state == FILL && h_v);
            case (state)
                IDLE:    state <= xfer ? FILL : IDLE;
                FILL:    state <= h_v ? RUN : FILL;
                RUN:     state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end
`ifdef FX2FP_FEEDER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) underrun_cnt <= '0;
        else if (underrun && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
    end
`endif
endmodule

// File: doc/fx2fp_feeder.md
FX2FP_FEEDER -- requirements
Module: fx2fp_feeder

Interface
REQ-001 SHALL have parameter PERIOD, default 11: cycles per filter sample slot; legal range 4..255.
REQ-002 SHALL have parameter IN_W, default 16: width of the signed fixed-point input; legal range 2..24.
REQ-003 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port s_valid  in  1  upstream sample valid.
REQ-006 SHALL have port s_data  in  IN_W  two's-complement integer sample.
REQ-007 SHALL have port s_ready  out  1  accept; a transfer occurs when s_valid and s_ready are both 1.
REQ-008 SHALL have port start  out  1  run enable to the downstream filter.
REQ-009 SHALL have port o_sample  out  32  IEEE-754 single, held constant between slot boundaries.
REQ-010 SHALL have port o_strobe  out  1  one-cycle pulse on the cycle o_sample takes a new value.
REQ-011 SHALL have port underrun  out  1  one-cycle pulse at a slot boundary with no converted sample ready.

Function
REQ-012 SHALL convert s_data to an exact float: sign = MSB; magnitude = |s_data|, with -2^(IN_W-1) handled without overflow; exponent = 127 + index of leading one; mantissa = the bits below the leading one, left-aligned, zero-filled.
REQ-013 SHALL map input 0 to 0x00000000 (positive zero).
REQ-014 SHALL perform the conversion in two register stages, then a one-entry hold register: a sample accepted in cycle t is in the hold register at t+2.
REQ-015 SHALL drive s_ready = 1 only when no sample is in stage 1, stage 2 or hold, and the FSM is not in reset.
REQ-016 SHALL implement FSM states IDLE, FILL, RUN.
REQ-017 IDLE: start = 0; on transfer -> FILL.
REQ-018 FILL: start = 0; when the hold register becomes valid -> RUN; on the entry cycle, load o_sample, pulse o_strobe, clear hold and set slot counter = 0.
REQ-019 RUN: start = 1; slot counter counts 0..PERIOD-1 and wraps to 0; the cycle where counter = PERIOD-1 is the slot boundary.
REQ-020 At a boundary with hold valid: o_sample <= hold on the next edge, o_strobe pulses in the following cycle, hold is cleared.
REQ-021 At a boundary with hold empty: o_sample is unchanged, no o_strobe, underrun pulses in the following cycle, RUN is kept.
REQ-022 s_ready is 0 on the boundary cycle that consumes hold and is 1 on the next cycle; accept and consume never coincide.
REQ-023 Transfers with s_ready = 0 SHALL be ignored; s_data is sampled only on a transfer.

Reset
REQ-024 Reset SHALL force: state IDLE, counter 0, all pipeline/hold valids 0, o_sample 0x00000000, start 0, o_strobe 0, underrun 0, s_ready 0 during reset.
REQ-025 Reset mid-operation SHALL discard any in-flight sample; the first output after reset comes only from a new transfer.

Configuration
REQ-026 With macro FX2FP_FEEDER_STATS_EN defined: output port underrun_cnt (16 bits) counts underrun pulses, saturates at 0xFFFF, is cleared by reset.
REQ-027 Without FX2FP_FEEDER_STATS_EN: the port and counter are absent; all other behaviour is identical.

Structure
REQ-028 Package fx2fp_pkg SHALL hold the FSM state enum, FP32_BIAS (127), FP32_ZERO, and the default PERIOD.
REQ-029 Conversion SHALL be a sub-module int_to_fp32 (IN_W parameter; two pipeline stages; valid in/out). Slot counter, FSM and hold register stay in fx2fp_feeder.

Verification
REQ-030 Single transfer, s_data = 1, with no further input -> o_sample = 0x3F800000 with o_strobe three cycles after the transfer; start = 1 from the same cycle; underrun pulse one cycle after the first boundary.
REQ-031 Corner values: -1 -> 0xBF800000; 32767 -> 0x46FFFE00; -32768 -> 0xC7000000; 0 -> 0x00000000; 1000 -> 0x447A0000 (IN_W = 16).
REQ-032 s_valid held high with PERIOD = 11 -> exactly one o_strobe every 11 cycles in RUN; no underrun; s_ready high one cycle per slot, then low until the next consume.
REQ-033 Upstream stalls for two full slots -> two underrun pulses; o_sample holds its last value; with STATS_EN, underrun_cnt = 2.
REQ-034 Reset asserted one cycle after a transfer -> all outputs match REQ-024; no o_strobe appears for the discarded sample.
REQ-035 STATS_EN build with underrun forced 65540 times -> underrun_cnt = 0xFFFF.
